// File: rtl/n64_cfg_mailbox_pkg.sv
// Shared constants for the SC64 config mailbox: version word, register map base
// indices and status-register bit positions.
package sc64;

    localparam logic [31:0] SC64_VER = 32'h5343_3634;

    typedef enum logic [3:0] {
        REG_SR        = 4'd0,
        REG_COMMAND   = 4'd1,
        REG_VERSION_H = 4'd2,
        REG_VERSION_L = 4'd3,
        REG_DATA_BASE = 4'd4
    } e_cfg_mailbox_reg;

    localparam int SR_CPU_READY   = 15;
    localparam int SR_BUSY        = 14;
    localparam int SR_QUEUE_FULL  = 13;
    localparam int SR_CMD_ERROR   = 12;
    localparam int SR_OVERFLOW    = 11;
    localparam int SR_IRQ_PENDING = 10;
    localparam int SR_IRQ_ENABLE  = 9;
    localparam int SR_IRQ_DISABLE = 8;

endpackage

// File: rtl/n64_cfg_mailbox_if.sv
// N64 PI-side register bus: one request, acknowledged one cycle later.
interface n64_cfg_mailbox_if;
    logic        bus_request;
    logic        bus_write;
    logic [15:0] bus_address;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    modport master (output bus_request, bus_write, bus_address, bus_wdata,
                    input  bus_rdata, bus_ack);
    modport slave  (input  bus_request, bus_write, bus_address, bus_wdata,
                    output bus_rdata, bus_ack);
endinterface

// File: rtl/n64_cfg_cmd_fifo.sv
// First-word-fall-through command queue; full/empty resolved by pointer MSB compare.
module n64_cfg_cmd_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && valid;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/n64_cfg_mailbox.sv
// N64-to-CPU config/command mailbox: bus FSM, register file, status/IRQ flags and
// a queued command path to the controller CPU.
module n64_cfg_mailbox import sc64::*; #(
    parameter int          NUM_DATA  = 2,
    parameter int          CMD_DEPTH = 4,
    parameter logic [31:0] VERSION   = SC64_VER
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    n64_soft_reset,
    n64_cfg_mailbox_if.slave        bus,
    output logic                    cmd_valid,
    input  logic                    cmd_pop,
    output logic [7:0]              cmd_opcode,
    output logic [32*NUM_DATA-1:0]  cmd_args,
    input  logic                    cpu_ready,
    input  logic                    cpu_done,
    input  logic                    cpu_error,
    input  logic [31:0]             cpu_wdata,
    input  logic [NUM_DATA-1:0]     cpu_data_write,
    output logic                    irq
);
    localparam int NUM_REGS  = 4 + 2*NUM_DATA;
    localparam int IW        = $clog2(NUM_REGS);
    localparam int DATA_BASE = int'(REG_DATA_BASE);
    localparam int FW        = 8 + 32*NUM_DATA;
    localparam int CW        = $clog2(CMD_DEPTH) + 1;

    typedef enum logic {S_IDLE, S_WAIT} bus_state_t;

    bus_state_t           state;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        rd_idx;
    logic                 rd_sel;
    logic                 mapped;
    logic                 wr;
    logic                 sr_wr;
    logic                 cmd_wr;
    logic [NUM_DATA-1:0]  data_wr_h;
    logic [NUM_DATA-1:0]  data_wr_l;
    logic [31:0]          data_q [NUM_DATA];
    logic [32*NUM_DATA-1:0] snapshot;
    logic [FW-1:0]        head;
    logic                 q_full;
    logic [CW-1:0]        q_count;
    logic                 pop_eff;
    logic                 in_flight;
    logic                 cmd_error;
    logic                 overflow;
    logic                 irq_pending;
    logic                 irq_enable;
    logic [7:0]           last_opcode;
    logic [15:0]          sr;
    logic [15:0]          rdata;
    logic                 unused_addr;

    assign idx         = bus.bus_address[IW:1];
    assign unused_addr = ^bus.bus_address[13:IW+1] ^ bus.bus_address[0];
    assign mapped      = (bus.bus_address[15:14] == 2'b00) && (int'(idx) < NUM_REGS);
    assign wr          = (state == S_IDLE) && bus.bus_request && bus.bus_write && mapped;
    assign sr_wr       = wr && (idx == IW'(REG_SR));
    assign cmd_wr      = wr && (idx == IW'(REG_COMMAND));
    assign pop_eff     = cmd_pop && cmd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            bus.bus_ack <= 1'b0;
            rd_idx      <= '0;
            rd_sel      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.bus_ack <= bus.bus_request;
                    if (bus.bus_request) begin
                        state  <= S_WAIT;
                        rd_idx <= idx;
                        rd_sel <= mapped;
                    end
                end
                default: begin
                    bus.bus_ack <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_wr_h = '0;
        data_wr_l = '0;
        snapshot  = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
            data_wr_h[i]        = wr && (idx == IW'(DATA_BASE + 2*i));
            data_wr_l[i]        = wr && (idx == IW'(DATA_BASE + 2*i + 1));
            snapshot[32*i +: 32] = data_q[i];
        end
    end

    // N64 halfword writes are applied after the CPU word so they win their half.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DATA; i++) begin
            if (reset) begin
                data_q[i] <= '0;
            end else begin
                if (cpu_data_write[i]) data_q[i]        <= cpu_wdata;
                if (data_wr_h[i])      data_q[i][31:16] <= bus.bus_wdata;
                if (data_wr_l[i])      data_q[i][15:0]  <= bus.bus_wdata;
            end
        end
    end

    n64_cfg_cmd_fifo #(.WIDTH(FW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (n64_soft_reset),
        .push  (cmd_wr),
        .pop   (cmd_pop),
        .din   ({bus.bus_wdata[7:0], snapshot}),
        .dout  (head),
        .valid (cmd_valid),
        .full  (q_full),
        .count (q_count)
    );

    assign cmd_opcode = cmd_valid ? head[FW-1 -: 8] : 8'd0;
    assign cmd_args   = cmd_valid ? head[32*NUM_DATA-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_flight   <= 1'b0;
            cmd_error   <= 1'b0;
            overflow    <= 1'b0;
            irq_pending <= 1'b0;
            irq_enable  <= 1'b0;
            last_opcode <= '0;
        end else begin
            if (cmd_wr)   last_opcode <= bus.bus_wdata[7:0];
            if (cpu_done) cmd_error   <= cpu_error;
            if (n64_soft_reset) begin
                in_flight   <= 1'b0;
                overflow    <= 1'b0;
                irq_pending <= 1'b0;
                irq_enable  <= 1'b0;
            end else begin
                if (pop_eff)       in_flight <= 1'b1;
                else if (cpu_done) in_flight <= 1'b0;
                // A completion arriving with a W1C keeps the new event pending.
                if (cpu_done)                                  irq_pending <= 1'b1;
                else if (sr_wr && bus.bus_wdata[SR_IRQ_PENDING]) irq_pending <= 1'b0;
                if (sr_wr && bus.bus_wdata[SR_IRQ_DISABLE])     irq_enable <= 1'b0;
                else if (sr_wr && bus.bus_wdata[SR_IRQ_ENABLE]) irq_enable <= 1'b1;
                if (cmd_wr && q_full && !pop_eff)               overflow <= 1'b1;
                else if (sr_wr && bus.bus_wdata[SR_OVERFLOW])   overflow <= 1'b0;
            end
        end
    end

    assign irq = irq_pending && irq_enable;
    assign sr  = {cpu_ready, (in_flight || cmd_valid), q_full, cmd_error, overflow,
                  irq_pending, irq_enable, 5'd0, 4'(q_count)};

    always_comb begin
        rdata = '0;
        if (bus.bus_ack && rd_sel) begin
            if (rd_idx == IW'(REG_SR))        rdata = sr;
            if (rd_idx == IW'(REG_COMMAND))   rdata = {8'd0, last_opcode};
            if (rd_idx == IW'(REG_VERSION_H)) rdata = VERSION[31:16];
            if (rd_idx == IW'(REG_VERSION_L)) rdata = VERSION[15:0];
            for (int i = 0; i < NUM_DATA; i++) begin
                if (rd_idx == IW'(DATA_BASE + 2*i))     rdata = data_q[i][31:16];
                if (rd_idx == IW'(DATA_BASE + 2*i + 1)) rdata = data_q[i][15:0];
            end
        end
    end

    assign bus.bus_rdata = rdata;

endmodule

// File: tb/tb_n64_cfg_mailbox.sv
// Directed bench for n64_cfg_mailbox with a queue-based reference model checked every cycle.
module tb_n64_cfg_mailbox;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        n64_soft_reset = 1'b0;
    logic        cmd_valid;
    logic        cmd_pop = 1'b0;
    logic [7:0]  cmd_opcode;
    logic [63:0] cmd_args;
    logic        cpu_ready = 1'b0;
    logic        cpu_done = 1'b0;
    logic        cpu_error = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [1:0]  cpu_data_write = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    n64_cfg_mailbox_if bus_if ();

    n64_cfg_mailbox #(.NUM_DATA(2), .CMD_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .n64_soft_reset (n64_soft_reset),
        .bus            (bus_if),
        .cmd_valid      (cmd_valid),
        .cmd_pop        (cmd_pop),
        .cmd_opcode     (cmd_opcode),
        .cmd_args       (cmd_args),
        .cpu_ready      (cpu_ready),
        .cpu_done       (cpu_done),
        .cpu_error      (cpu_error),
        .cpu_wdata      (cpu_wdata),
        .cpu_data_write (cpu_data_write),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]  op;
        logic [63:0] args;
    } cmd_t;

    cmd_t        mq[$];
    logic [31:0] md [2];
    bit          m_inflight, m_err, m_ovf, m_pend, m_en, m_ack, m_ack_wr;
    logic [15:0] m_addr;
    logic [7:0]  m_lastop;

    function automatic logic [15:0] mread(input logic [15:0] a);
        int          ix;
        logic [31:0] w;
        if (a[15:14] != 2'b00) return 16'h0000;
        ix = int'(a[3:1]);
        case (ix)
            0: return {cpu_ready, (m_inflight || mq.size() > 0), (mq.size() == 4), m_err,
                       m_ovf, m_pend, m_en, 5'd0, 4'(mq.size())};
            1: return {8'h00, m_lastop};
            2: return 16'h5343;
            3: return 16'h3634;
            default: begin
                w = md[(ix - 4) / 2];
                return ix[0] ? w[15:0] : w[31:16];
            end
        endcase
    endfunction

    always @(posedge clk) begin
        bit          acc, wr, popn;
        int          ix;
        cmd_t        c;
        logic [31:0] nd [2];
        if (reset) begin
            mq.delete();
            md[0] = '0; md[1] = '0;
            m_inflight = 0; m_err = 0; m_ovf = 0; m_pend = 0; m_en = 0;
            m_ack = 0; m_ack_wr = 0; m_addr = '0; m_lastop = '0;
        end else begin
            acc  = bus_if.bus_request && !m_ack;
            ix   = int'(bus_if.bus_address[3:1]);
            wr   = acc && bus_if.bus_write && (bus_if.bus_address[15:14] == 2'b00);
            popn = cmd_pop && (mq.size() > 0);
            c.op   = bus_if.bus_wdata[7:0];
            c.args = {md[1], md[0]};
            nd = md;
            for (int i = 0; i < 2; i++) begin
                if (cpu_data_write[i]) nd[i] = cpu_wdata;
                if (wr && ix == 4 + 2*i) nd[i][31:16] = bus_if.bus_wdata;
                if (wr && ix == 5 + 2*i) nd[i][15:0]  = bus_if.bus_wdata;
            end
            if (popn) void'(mq.pop_front());
            if (wr && ix == 1) begin
                m_lastop = bus_if.bus_wdata[7:0];
                if (mq.size() < 4) mq.push_back(c);
                else m_ovf = 1;
            end
            if (cpu_done) begin
                m_err = cpu_error;
                m_pend = 1;
                m_inflight = 0;
            end
            if (popn) m_inflight = 1;
            if (wr && ix == 0) begin
                if (bus_if.bus_wdata[11]) m_ovf = 0;
                if (bus_if.bus_wdata[10] && !cpu_done) m_pend = 0;
                if (bus_if.bus_wdata[9]) m_en = 1;
                if (bus_if.bus_wdata[8]) m_en = 0;
            end
            if (n64_soft_reset) begin
                mq.delete();
                m_inflight = 0; m_pend = 0; m_en = 0; m_ovf = 0;
            end
            m_ack    = acc;
            m_ack_wr = bus_if.bus_write;
            m_addr   = bus_if.bus_address;
            md       = nd;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_ack", 64'(bus_if.bus_ack), 64'(m_ack));
            if (m_ack && !m_ack_wr) chk("cmp_rdata", 64'(bus_if.bus_rdata), 64'(mread(m_addr)));
            else if (!m_ack)        chk("cmp_rdata_idle", 64'(bus_if.bus_rdata), 64'd0);
            chk("cmp_valid", 64'(cmd_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("cmp_opcode", 64'(cmd_opcode), 64'(mq[0].op));
                chk("cmp_args", cmd_args, mq[0].args);
            end
            chk("cmp_irq", 64'(irq), 64'(m_pend && m_en));
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                              output logic [15:0] rd);
        int n;
        bus_if.bus_request = 1'b1;
        bus_if.bus_write   = w;
        bus_if.bus_address = a;
        bus_if.bus_wdata   = d;
        @(posedge clk); #1;
        bus_if.bus_request = 1'b0;
        n = 0;
        while (!bus_if.bus_ack && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_seen", 64'(bus_if.bus_ack), 64'd1);
        rd = bus_if.bus_rdata;
        @(posedge clk); #1;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        bus_access(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] v;
        bus_access(1'b0, a, 16'h0, v);
        chk(name, 64'(v), 64'(exp));
    endtask

    task automatic pulse_pop();
        cmd_pop = 1'b1;
        @(posedge clk); #1;
        cmd_pop = 1'b0;
    endtask

    task automatic pulse_done(input logic e);
        cpu_done = 1'b1;
        cpu_error = e;
        @(posedge clk); #1;
        cpu_done = 1'b0;
        cpu_error = 1'b0;
    endtask

    logic [3:0] acks;

    initial begin
        bus_if.bus_request = 1'b0;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_address = '0;
        bus_if.bus_wdata   = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        chk("reset_irq", 64'(irq), 64'd0);
        chk("reset_valid", 64'(cmd_valid), 64'd0);
        rd_chk("version_h", 16'h0004, 16'h5343);
        rd_chk("version_l", 16'h0006, 16'h3634);
        rd_chk("sr_reset", 16'h0000, 16'h0000);

        bus_wr(16'h0008, 16'h1234);
        bus_wr(16'h000A, 16'h5678);
        bus_wr(16'h0002, 16'h0042);
        chk("push_valid", 64'(cmd_valid), 64'd1);
        chk("push_opcode", 64'(cmd_opcode), 64'h42);
        chk("push_args0", 64'(cmd_args[31:0]), 64'h1234_5678);
        rd_chk("sr_busy", 16'h0000, 16'h4001);
        rd_chk("cmd_readback", 16'h0002, 16'h0042);
        rd_chk("unmapped", 16'h4000, 16'h0000);

        bus_wr(16'h0000, 16'h0200);
        pulse_pop();
        pulse_done(1'b1);
        chk("irq_set", 64'(irq), 64'd1);
        rd_chk("sr_done_err", 16'h0000, 16'h1600);
        bus_wr(16'h0000, 16'h0400);
        chk("irq_clr", 64'(irq), 64'd0);
        rd_chk("sr_after_w1c", 16'h0000, 16'h1200);

        for (int k = 1; k <= 5; k++) bus_wr(16'h0002, 16'(k));
        rd_chk("sr_full_ovf", 16'h0000, 16'h7A04);
        bus_wr(16'h0000, 16'h0800);
        rd_chk("sr_ovf_clr", 16'h0000, 16'h7204);
        chk("full_head", 64'(cmd_opcode), 64'h01);

        cpu_data_write = 2'b10;
        cpu_wdata = 32'hAAAA_BBBB;
        bus_if.bus_request = 1'b1;
        bus_if.bus_write   = 1'b1;
        bus_if.bus_address = 16'h000E;
        bus_if.bus_wdata   = 16'h1111;
        @(posedge clk); #1;
        cpu_data_write = 2'b00;
        bus_if.bus_request = 1'b0;
        @(posedge clk); #1;
        rd_chk("merge_h", 16'h000C, 16'hAAAA);
        rd_chk("merge_l", 16'h000E, 16'h1111);

        pulse_pop();
        cpu_ready = 1'b1;
        n64_soft_reset = 1'b1;
        @(posedge clk); #1;
        n64_soft_reset = 1'b0;
        chk("soft_valid", 64'(cmd_valid), 64'd0);
        rd_chk("sr_soft", 16'h0000, 16'h9000);
        rd_chk("soft_d0h", 16'h0008, 16'h1234);
        rd_chk("soft_d1l", 16'h000E, 16'h1111);

        for (int k = 0; k < 4; k++) bus_wr(16'h0002, 16'(8'h10 + k));
        chk("refill_args", cmd_args, 64'hAAAA_1111_1234_5678);
        cmd_pop = 1'b1;
        bus_if.bus_request = 1'b1;
        bus_if.bus_write   = 1'b1;
        bus_if.bus_address = 16'h0002;
        bus_if.bus_wdata   = 16'h0014;
        @(posedge clk); #1;
        cmd_pop = 1'b0;
        bus_if.bus_request = 1'b0;
        @(posedge clk); #1;
        rd_chk("sr_full_pop", 16'h0000, 16'hF004);
        chk("full_pop_head", 64'(cmd_opcode), 64'h11);

        bus_if.bus_request = 1'b1;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_address = 16'h0006;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            acks[k] = bus_if.bus_ack;
        end
        bus_if.bus_request = 1'b0;
        chk("b2b_acks", 64'(acks), 64'h5);
        @(posedge clk); #1;

        bus_if.bus_request = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_request = 1'b0;
        reset = 1'b0;
        chk("abort_ack", 64'(bus_if.bus_ack), 64'd0);
        chk("abort_valid", 64'(cmd_valid), 64'd0);
        rd_chk("reset_data", 16'h0008, 16'h0000);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
